// File: rtl/io_input_latch.sv
// Syncs and debounces up/down buttons, latches jump presses and frame ticks as sticky flags.
// Latency: 2 + DEBOUNCE_CYCLES cycles per button edge, 2 cycles per frame tick; no backpressure, acks only clear flags.
module io_input_latch #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int FRAME_W         = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               up,
  input  logic               down,
  input  logic               screen_end,
  input  logic               ack_jump,
  input  logic               ack_frame,
  output logic               io_jump,
  output logic               io_duck,
  output logic               jump_pending,
  output logic               frame_pending,
  output logic               frame_overrun,
  output logic [FRAME_W-1:0] frame_count
);

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

  logic             up_meta;
  logic             up_sync;
  logic             down_meta;
  logic             down_sync;
  logic [CNT_W-1:0] up_cnt;
  logic [CNT_W-1:0] down_cnt;
  logic             screen_end_r;
  logic             screen_end_d;
  logic             jump_rise;
  logic             frame_tick;

  // up/down are truly asynchronous; screen_end shares our clock so one stage suffices
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      up_meta      <= 1'b0;
      up_sync      <= 1'b0;
      down_meta    <= 1'b0;
      down_sync    <= 1'b0;
      screen_end_r <= 1'b0;
      screen_end_d <= 1'b0;
    end else begin
      up_meta      <= up;
      up_sync      <= up_meta;
      down_meta    <= down;
      down_sync    <= down_meta;
      screen_end_r <= screen_end;
      screen_end_d <= screen_end_r;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      up_cnt  <= '0;
      io_jump <= 1'b0;
    end else if (up_sync == io_jump) begin
      up_cnt <= '0;
    end else if (up_cnt == CNT_LAST) begin
      io_jump <= up_sync;
      up_cnt  <= '0;
    end else begin
      up_cnt <= up_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      down_cnt <= '0;
      io_duck  <= 1'b0;
    end else if (down_sync == io_duck) begin
      down_cnt <= '0;
    end else if (down_cnt == CNT_LAST) begin
      io_duck  <= down_sync;
      down_cnt <= '0;
    end else begin
      down_cnt <= down_cnt + CNT_ONE;
    end
  end

  // Fires on the very edge where io_jump commits 0->1
  assign jump_rise  = up_sync && !io_jump && (up_cnt == CNT_LAST);
  assign frame_tick = screen_end_r && !screen_end_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jump_pending <= 1'b0;
    end else if (jump_rise) begin
      jump_pending <= 1'b1;
    end else if (ack_jump) begin
      jump_pending <= 1'b0;
    end
  end

  // A tick coinciding with an ack is a fresh event, so it never counts as an overrun
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_count   <= '0;
      frame_pending <= 1'b0;
      frame_overrun <= 1'b0;
    end else if (frame_tick) begin
      frame_count   <= frame_count + FRAME_ONE;
      frame_pending <= 1'b1;
      if (ack_frame) begin
        frame_overrun <= 1'b0;
      end else if (frame_pending) begin
        frame_overrun <= 1'b1;
      end
    end else if (ack_frame) begin
      frame_pending <= 1'b0;
      frame_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_input_latch.sv
// Bench for io_input_latch: directed scenarios plus random traffic, every cycle scored
// against a history-window reference model through an expected-value queue.
module tb_io_input_latch;

  localparam int DC = 4;
  localparam int FW = 8;  // narrow frame counter keeps the wrap scenario short

  logic          clock;
  logic          reset;
  logic          up;
  logic          down;
  logic          screen_end;
  logic          ack_jump;
  logic          ack_frame;
  logic          io_jump;
  logic          io_duck;
  logic          jump_pending;
  logic          frame_pending;
  logic          frame_overrun;
  logic [FW-1:0] frame_count;

  io_input_latch #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3),
    .FRAME_W        (FW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .up           (up),
    .down         (down),
    .screen_end   (screen_end),
    .ack_jump     (ack_jump),
    .ack_frame    (ack_frame),
    .io_jump      (io_jump),
    .io_duck      (io_duck),
    .jump_pending (jump_pending),
    .frame_pending(frame_pending),
    .frame_overrun(frame_overrun),
    .frame_count  (frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic          io_jump;
    logic          io_duck;
    logic          jump_pending;
    logic          frame_pending;
    logic          frame_overrun;
    logic [FW-1:0] frame_count;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit          m_jump, m_duck, m_jp, m_fp, m_fo;
  int unsigned m_frames;
  bit          up_p1, up_p2, dn_p1, dn_p2, se_p1, se_p2;
  bit [DC-1:0] up_win, dn_win;
  bit          prev_jump, tick;
  obs_t        m_obs;

  // A level is accepted once the last DC synchronised samples all agree on it
  function automatic bit settle(input bit [DC-1:0] win, input bit stable);
    if (win == {DC{1'b1}}) return 1'b1;
    if (win == {DC{1'b0}}) return 1'b0;
    return stable;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_jump = 0; m_duck = 0; m_jp = 0; m_fp = 0; m_fo = 0; m_frames = 0;
      up_p1 = 0; up_p2 = 0; dn_p1 = 0; dn_p2 = 0; se_p1 = 0; se_p2 = 0;
      up_win = '0; dn_win = '0;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      prev_jump = m_jump;
      // Raw level seen two edges ago is what the debouncer sees now
      up_win = {up_win[DC-2:0], up_p2};
      dn_win = {dn_win[DC-2:0], dn_p2};
      up_p2 = up_p1; up_p1 = up;
      dn_p2 = dn_p1; dn_p1 = down;
      m_jump = settle(up_win, m_jump);
      m_duck = settle(dn_win, m_duck);
      if (m_jump && !prev_jump) m_jp = 1;
      else if (ack_jump)        m_jp = 0;
      tick  = se_p1 && !se_p2;
      se_p2 = se_p1; se_p1 = screen_end;
      if (tick) begin
        m_frames = m_frames + 1;
        if (ack_frame) m_fo = 0;
        else if (m_fp) m_fo = 1;
        m_fp = 1;
      end else if (ack_frame) begin
        m_fp = 0;
        m_fo = 0;
      end
      m_obs.io_jump       = m_jump;
      m_obs.io_duck       = m_duck;
      m_obs.jump_pending  = m_jp;
      m_obs.frame_pending = m_fp;
      m_obs.frame_overrun = m_fo;
      m_obs.frame_count   = m_frames[FW-1:0];
      exp_q.push_back(m_obs);
    end
  end

  obs_t mon_exp, mon_act;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {io_jump, io_duck, jump_pending, frame_pending, frame_overrun, frame_count};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL outputs t=%0t: got jump=%b duck=%b jp=%b fp=%b fo=%b cnt=%0d, expected jump=%b duck=%b jp=%b fp=%b fo=%b cnt=%0d",
                 $time, mon_act.io_jump, mon_act.io_duck, mon_act.jump_pending, mon_act.frame_pending,
                 mon_act.frame_overrun, mon_act.frame_count, mon_exp.io_jump, mon_exp.io_duck,
                 mon_exp.jump_pending, mon_exp.frame_pending, mon_exp.frame_overrun, mon_exp.frame_count);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  initial begin
    reset = 1'b1; up = 1'b0; down = 1'b0; screen_end = 1'b0;
    ack_jump = 1'b0; ack_frame = 1'b0;
    step(3);
    reset = 1'b0;
    step(2);

    // Clean press, ack, release
    up = 1'b1; step(10);
    ack_jump = 1'b1; step(1); ack_jump = 1'b0; step(2);
    up = 1'b0; step(10);

    // Short glitches must never reach io_jump
    repeat (5) begin
      up = 1'b1; step(3);
      up = 1'b0; step(3);
    end
    step(6);

    // Held frame level, second tick without ack, then ack
    screen_end = 1'b1; step(10); screen_end = 1'b0; step(3);
    screen_end = 1'b1; step(2);  screen_end = 1'b0; step(3);
    ack_frame = 1'b1; step(1); ack_frame = 1'b0; step(2);

    // ack_jump lands on the edge where io_jump rises
    up = 1'b1; step(5);
    ack_jump = 1'b1; step(1); ack_jump = 1'b0; step(3);

    // Pending frame, then a tick coinciding with ack_frame
    screen_end = 1'b1; step(2); screen_end = 1'b0; step(3);
    screen_end = 1'b1; step(1);
    ack_frame = 1'b1; step(1);
    ack_frame = 1'b0; screen_end = 1'b0; step(3);

    // Asynchronous reset while flags are set
    reset = 1'b1;
    #1;
    check_bit("async_rst_io_jump",       io_jump,       1'b0);
    check_bit("async_rst_jump_pending",  jump_pending,  1'b0);
    check_bit("async_rst_frame_pending", frame_pending, 1'b0);
    check_bit("async_rst_frame_overrun", frame_overrun, 1'b0);
    checks++;
    if (frame_count !== '0) begin
      errors++;
      $display("FAIL async_rst_frame_count: got %0d, expected 0", frame_count);
    end
    step(2);
    reset = 1'b0;
    step(10);

    // Counter wrap, then duck press leaves jump_pending alone
    repeat ((1 << FW) - 1) begin
      screen_end = 1'b1; step(1);
      screen_end = 1'b0; step(1);
    end
    screen_end = 1'b1; step(1); screen_end = 1'b0; step(4);
    checks++;
    if (frame_count !== '0) begin
      errors++;
      $display("FAIL frame_wrap: got %0d, expected 0", frame_count);
    end
    check_bit("jump_pending_before_duck", jump_pending, 1'b1);
    down = 1'b1; step(8);
    check_bit("duck_level", io_duck, 1'b1);
    check_bit("jump_pending_after_duck", jump_pending, 1'b1);
    down = 1'b0; up = 1'b0; step(8);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) up = ~up;
      if ($urandom_range(0, 9) == 0) down = ~down;
      if ($urandom_range(0, 3) == 0) screen_end = ~screen_end;
      ack_jump  = ($urandom_range(0, 7) == 0);
      ack_frame = ($urandom_range(0, 7) == 0);
      step(1);
    end
    ack_jump = 1'b0; ack_frame = 1'b0;
    step(4);
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
